// File: rtl/reflet_write_fifo_pkg.sv
// Register offsets and STATUS bit positions shared by the write FIFO and its users.
package reflet_write_fifo_pkg;

    localparam logic [1:0] WFIFO_DATA   = 2'd0;
    localparam logic [1:0] WFIFO_STATUS = 2'd1;
    localparam logic [1:0] WFIFO_COUNT  = 2'd2;
    localparam logic [1:0] WFIFO_CTRL   = 2'd3;

    localparam int WFIFO_EMPTY = 0;
    localparam int WFIFO_FULL  = 1;
    localparam int WFIFO_OVF   = 2;
    localparam int WFIFO_IRQ   = 3;

endpackage

// File: rtl/reflet_fifo_core.sv
// Generic register-based FIFO with push/pop/flush; flush beats push and pop.
// Zero-latency head (head_dat_o reads 0 when empty); a pop frees space for a same-cycle push.
module reflet_fifo_core #(
    parameter int W   = 8,
    parameter int DL2 = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  logic [W-1:0]   push_dat_i,
    input  logic           pop_i,
    input  logic           flush_i,
    output logic [W-1:0]   head_dat_o,
    output logic [DL2:0]   count_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int DEPTH = 1 << DL2;
    localparam int CW    = DL2 + 1;

    logic [W-1:0]   mem_q [DEPTH];
    logic [DL2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DL2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // Masking the stale slot keeps out_data at 0 whenever nothing is queued.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/reflet_write_fifo.sv
// Memory-mapped write FIFO on the reflet_cpu bus; REFLET_WRITE_FIFO_IRQ_EN adds a level irq.
// Bus reads 1 cycle latency, stream head visible 1 cycle after push; pushes while full are dropped.
module reflet_write_fifo
    import reflet_write_fifo_pkg::*;
#(
    parameter int                    wordsize   = 8,
    parameter logic [wordsize-1:0]   base_addr  = 8'h80,
    parameter int                    depth_log2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic [wordsize-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef REFLET_WRITE_FIFO_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam int CW = depth_log2 + 1;

    logic [wordsize-1:0] offset;
    logic                in_win;
    logic [1:0]          sel;
    logic                wr_data, wr_status, flush, pop;
    logic                full, empty;
    logic [CW-1:0]       count;
    logic                ovf_q, ovf_d;
    logic [wordsize-1:0] rdata_d, rdata_q;
    logic                irq_bit;

    // Unsigned subtraction makes addresses below the base wrap far outside the window.
    assign offset    = addr - base_addr;
    assign in_win    = (offset[wordsize-1:2] == '0);
    assign sel       = offset[1:0];
    assign wr_data   = write_en && in_win && (sel == WFIFO_DATA);
    assign wr_status = write_en && in_win && (sel == WFIFO_STATUS);
    assign flush     = write_en && in_win && (sel == WFIFO_CTRL) && data_in[0];
    assign pop       = out_valid && out_ready;

    reflet_fifo_core #(
        .W   (wordsize),
        .DL2 (depth_log2)
    ) u_core (
        .clk_i      (clk),
        .rst_ni     (reset),
        .push_i     (wr_data),
        .push_dat_i (data_in),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_dat_o (out_data),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign out_valid = !empty;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && data_in[WFIFO_OVF]) ovf_d = 1'b0;
        if (wr_data && full && !pop && !flush) ovf_d = 1'b1;
    end

`ifdef REFLET_WRITE_FIFO_IRQ_EN
    localparam logic [CW-1:0] HALF = CW'(1) << (depth_log2 - 1);

    logic          irq_q;
    logic          acc_push, acc_pop;
    logic [CW-1:0] count_nxt;

    // irq is registered from next-state values so it moves on the same edge as count/overflow.
    assign acc_pop   = pop && !flush;
    assign acc_push  = wr_data && (!full || acc_pop) && !flush;
    assign count_nxt = flush ? '0 : (count + CW'(acc_push) - CW'(acc_pop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= (count_nxt >= HALF) || ovf_d;
    end

    assign irq     = irq_q;
    assign irq_bit = irq_q;
`else
    assign irq_bit = 1'b0;
`endif

    always_comb begin
        rdata_d = '0;
        if (in_win) begin
            case (sel)
                WFIFO_DATA:   rdata_d = out_data;
                WFIFO_STATUS: begin
                    rdata_d[WFIFO_EMPTY] = empty;
                    rdata_d[WFIFO_FULL]  = full;
                    rdata_d[WFIFO_OVF]   = ovf_q;
                    rdata_d[WFIFO_IRQ]   = irq_bit;
                end
                WFIFO_COUNT:  rdata_d[CW-1:0] = count;
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_out = rdata_q;

endmodule

// File: doc/reflet_write_fifo.md
# reflet_write_fifo

Memory-mapped write FIFO that sits on the `reflet_cpu` data bus, directly downstream of the CPU's store path. CPU stores to its data register are buffered and drained on a valid/ready stream toward a consumer such as a UART, checker or trace sink. Status and fill-level registers let firmware poll for space. Read data follows the bus convention: it is zero when the block is not addressed, so it can be OR-combined with ROM and other peripherals.

## Interface
Parameters:
- `wordsize`, 8: bus data and address width.
- `base_addr`, 8'h80: first byte of the 4-register window.
- `depth_log2`, 2: FIFO depth is 2**depth_log2 entries.

Ports:
- `clk`  in  1  — single system clock. Everything is rising-edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `addr`  in  wordsize  — CPU bus address.
- `data_in`  in  wordsize  — CPU write data (CPU `data_out`).
- `write_en`  in  1  — CPU write strobe.
- `data_out`  out  wordsize  — read data to the CPU, zero when not selected.
- `out_data`  out  wordsize  — head-of-FIFO word.
- `out_valid`  out  1  — the FIFO is non-empty.
- `out_ready`  in  1  — consumer accepts `out_data`.

## Operation
- Register map, offset from `base_addr`:
  - +0 DATA. A write pushes `data_in`. A read returns the head word without popping.
  - +1 STATUS, read: bit0 empty, bit1 full, bit2 overflow (sticky). Write: bit2=1 clears overflow. Other bits are ignored.
  - +2 COUNT. Read returns the fill level, 0..2**depth_log2.
  - +3 CTRL. Write bit0=1 flushes the FIFO, setting count to 0 and pointers to 0. Reads return 0.
- A push while full discards the data, sets overflow, and leaves count unchanged.
- A pop occurs when `out_valid && out_ready`.
- Simultaneous push and pop:
  - When not full and not empty, both take effect and count is unchanged.
  - When empty, only the push happens; data is never bypassed.
  - When full, the pop frees space and the push is accepted in the same cycle. Overflow is not set.
- If a flush and a pop land in the same cycle, the flush wins and the pop is lost. `out_valid` drops the next cycle.
- Pointers wrap modulo depth. Count is held in depth_log2+1 bits.
- Writes to addresses outside the window are ignored.

## Timing
- All state updates on the rising `clk` edge. Reset asserted (low) clears everything immediately.
- Reset values:
  - `data_out`, `out_data`, `out_valid` = 0.
  - Pointers, count and overflow = 0.
- Reset mid-operation discards all buffered words.
- Read latency is 1 cycle. `data_out` is registered from `addr` at edge N and valid after edge N, matching the synchronous ROM on the same bus. When the address is outside the window, the registered value is 0.
- A pushed word is visible on `out_data`/`out_valid` the cycle after the write edge.
- `out_valid` falls the cycle after the last pop.
- `out_data` is stable while `out_valid && !out_ready`.
- A STATUS or COUNT read reflects state after the previous edge, so a write at edge N is seen by a read addressed at edge N+1.

## Configuration
- Macro `REFLET_WRITE_FIFO_IRQ_EN`. When defined:
  - Adds port `irq`  out  1, reset 0, registered.
  - `irq` is high while count ≥ half depth, or while overflow is set.
  - STATUS bit3 mirrors `irq`.
- When undefined: there is no `irq` port, and STATUS bit3 reads 0.

## Structure
- Package `reflet_write_fifo_pkg` holds:
  - Register offsets: `WFIFO_DATA`=0, `WFIFO_STATUS`=1, `WFIFO_COUNT`=2, `WFIFO_CTRL`=3.
  - STATUS bit indices: `WFIFO_EMPTY`, `WFIFO_FULL`, `WFIFO_OVF`, `WFIFO_IRQ`.
- Sub-module `reflet_fifo_core`: generic storage with push/pop/flush, count, full/empty.
- The top level holds address decode, STATUS/CTRL logic, overflow and the read-data register.

## Test plan
Each scenario uses wordsize 8, base 0x80 and depth 4.
- **Reset and idle:** after reset release, read 0x81 -> 0x01. Read 0x82 -> 0x00. `out_valid`=0. A read at 0x10 -> `data_out`=0.
- **Fill to full:** with `out_ready`=0, write 0x11, 0x22, 0x33, 0x44 to 0x80.
  - Read 0x82 -> 0x04. Read 0x81 -> 0x02.
  - `out_data`=0x11.
  - A 5th write of 0x55 -> 0x81 reads 0x06. Count stays 4.
  - Write 0x04 to 0x81 -> 0x81 reads 0x02.
- **Drain:** raise `out_ready` for 4 cycles -> stream 0x11, 0x22, 0x33, 0x44 in order. `out_valid` low after the 4th. 0x81 reads 0x01.
- **Simultaneous push and pop:**
  - When full with `out_ready`=1, write 0x66 -> count stays 4, overflow stays 0, and 0x66 emerges after 0x22..0x44.
  - When empty, a push with `out_ready`=1 is not popped in the same cycle.
- **Flush and wrap:** run 6 push/pop pairs to wrap the pointers. Then push 2 words and write 0x01 to 0x83 -> count 0, `out_valid`=0 next cycle.
- **Reset mid-stream and IRQ:** assert reset with 3 words queued -> all outputs 0 immediately. With `REFLET_WRITE_FIFO_IRQ_EN`:
  - `irq` rises after the 2nd push and falls after the pop that leaves 1 word.
  - An overflow holds `irq` high until STATUS bit2 is cleared.
